// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 byte transmitter driving open-drain clock/data via pull-low enables.
// Frame: inhibit, request-to-send, 11 device clocks, release wait, done/error pulse; accepts only when idle.
`timescale 1ns/1ps
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       send_ready,
    input  logic       ps2_clock_i,
    input  logic       ps2_data_i,
    output logic       ps2_clock_oe,
    output logic       ps2_data_oe,
    output logic       tx_active,
    output logic       done,
    output logic       error
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_REL, S_DONE, S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_clk_s1, r_clk_s2, r_clk_prev;
    logic               r_dat_s1, r_dat_s2;
    logic [8:0]         r_shreg;
    logic [3:0]         r_bit_idx;
    logic [INH_W-1:0]   r_inh_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_clk_oe, r_data_oe;
    logic               w_fall, w_accept, w_to_hit;
    logic               w_clk_oe_nxt, w_data_oe_nxt;

    assign w_fall       = r_clk_prev & ~r_clk_s2;
    assign w_accept     = send_valid & send_ready;
    assign w_to_hit     = (r_to_cnt == TO_LAST);
    assign ps2_clock_oe = r_clk_oe;
    assign ps2_data_oe  = r_data_oe;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; the timeout wins over a fall in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_accept) w_state_nxt = S_INHIBIT;
            S_INHIBIT:  if (r_inh_cnt == INH_LAST) w_state_nxt = S_REQ;
            S_REQ:      w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_to_hit)                          w_state_nxt = S_ERR;
                else if (w_fall && r_bit_idx == 4'd9)  w_state_nxt = S_ACK;
            end
            S_ACK: begin
                if (w_to_hit)    w_state_nxt = S_ERR;
                else if (w_fall) w_state_nxt = r_dat_s2 ? S_ERR : S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (w_to_hit)                  w_state_nxt = S_ERR;
                else if (r_clk_s2 && r_dat_s2) w_state_nxt = S_DONE;
            end
            S_DONE:     w_state_nxt = S_IDLE;
            S_ERR:      w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs; pin enables are computed one cycle ahead so the registered value lines up with the state
    always_comb begin
        send_ready    = (r_state == S_IDLE) & ~reset;
        tx_active     = (r_state != S_IDLE);
        done          = (r_state == S_DONE);
        error         = (r_state == S_ERR);
        w_clk_oe_nxt  = (w_state_nxt == S_INHIBIT);
        w_data_oe_nxt = 1'b0;
        case (r_state)
            S_INHIBIT: w_data_oe_nxt = (r_inh_cnt >= INH_PRE);
            S_REQ:     w_data_oe_nxt = 1'b1;
            S_SHIFT: begin
                if (w_to_hit)                w_data_oe_nxt = 1'b0;
                else if (!w_fall)            w_data_oe_nxt = r_data_oe;
                else if (r_bit_idx < 4'd9)   w_data_oe_nxt = ~r_shreg[r_bit_idx];
                else                         w_data_oe_nxt = 1'b0;
            end
            default:   w_data_oe_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clock_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_i;
            r_dat_s2   <= r_dat_s1;
            r_clk_oe   <= w_clk_oe_nxt;
            r_data_oe  <= w_data_oe_nxt;

            if (w_accept) r_shreg <= {~^send_data, send_data};

            if (r_state == S_INHIBIT) r_inh_cnt <= r_inh_cnt + 1'b1;
            else                      r_inh_cnt <= '0;

            if (r_state == S_REQ)
                r_bit_idx <= '0;
            else if (r_state == S_SHIFT && w_fall && !w_to_hit)
                r_bit_idx <= r_bit_idx + 1'b1;

            case (r_state)
                S_SHIFT, S_ACK, S_WAIT_REL: r_to_cnt <= w_fall ? '0 : r_to_cnt + 1'b1;
                default:                    r_to_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a behavioural PS/2 device on open-drain lines.
`timescale 1ns/1ps
module tb_ps2_host_transmitter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send_valid = 1'b0;
    logic [7:0] send_data = 8'h00;
    logic       send_ready;
    logic       ps2_clock_i, ps2_data_i;
    logic       ps2_clock_oe, ps2_data_oe;
    logic       tx_active, done, error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    bit         fdone = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_error = 0;
    int n_acc = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [9:0] exp_bits;   // {stop, parity, data[7:0]} in line order bit0 first
        int         exp_done;
        int         exp_err;
    } vec_t;
    vec_t vecs[4];

    assign ps2_clock_i = ~(ps2_clock_oe | dev_clk_low);
    assign ps2_data_i  = ~(ps2_data_oe  | dev_data_low);

    ps2_host_transmitter #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
        .clock(clock), .reset(reset), .send_valid(send_valid), .send_data(send_data),
        .send_ready(send_ready), .ps2_clock_i(ps2_clock_i), .ps2_data_i(ps2_data_i),
        .ps2_clock_oe(ps2_clock_oe), .ps2_data_oe(ps2_data_oe), .tx_active(tx_active),
        .done(done), .error(error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        #1;
        if (done) n_done++;
        if (error) n_error++;
        if (send_valid && send_ready) n_acc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        @(negedge clock);
        send_valid = 1'b1;
        send_data  = d;
        @(negedge clock);
        send_valid = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ps2_clock_oe == 1'b0 && ps2_data_oe == 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic dev_pulse();
        repeat (20) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clock);
        dev_clk_low = 1'b0;
    endtask

    // Device side: samples start at clock release, then each bit at the rising edge
    task automatic dev_frame(input logic ack, output logic st, output logic [9:0] bits);
        bit seen;
        bits = '0;
        st   = 1'b1;
        wait_req(seen);
        chk("req_seen", 32'(seen), 32'd1);
        if (seen) begin
            st = ps2_data_i;
            for (int k = 0; k < 10; k++) begin
                repeat (20) @(negedge clock);
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clock);
                bits[k] = ps2_data_i;
                dev_clk_low = 1'b0;
            end
            repeat (10) @(negedge clock);
            dev_data_low = ack;
            repeat (10) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
        end
    endtask

    initial begin
        logic       st;
        logic [9:0] bits;
        int         d0, e0, a0, clk_hi, first_d, err_at, k;
        bit         seen, oe_at_err;

        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0};
        vecs[1] = '{8'h80, 1'b1, 10'h280, 1, 0};
        vecs[2] = '{8'hA5, 1'b0, 10'h3A5, 0, 1};
        vecs[3] = '{8'hFF, 1'b1, 10'h3FF, 1, 0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
        chk("rst_data_oe",  32'(ps2_data_oe),  32'd0);
        chk("rst_tx_active", 32'(tx_active),   32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_error",    32'(error),        32'd0);
        chk("rst_ready",    32'(send_ready),   32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready",   32'(send_ready),   32'd1);

        // Test 1: inhibit timing and a full 0xED frame
        d0 = n_done; e0 = n_error;
        send_valid = 1'b1;
        send_data  = 8'hED;
        @(negedge clock);
        send_valid = 1'b0;
        chk("t1_tx_active", 32'(tx_active), 32'd1);
        clk_hi = 0; first_d = 0;
        for (int i = 1; i <= 21; i++) begin
            if (ps2_clock_oe) clk_hi++;
            if (ps2_data_oe && first_d == 0) first_d = i;
            if (i < 21) @(negedge clock);
        end
        chk("t1_clk_low_cycles", 32'(clk_hi), 32'd20);
        chk("t1_data_oe_rise",   32'(first_d), 32'd20);
        dev_frame(1'b1, st, bits);
        chk("t1_start", 32'(st), 32'd0);
        chk("t1_bits",  32'(bits), 32'h3ED);
        repeat (10) @(negedge clock);
        chk("t1_done",  32'(n_done - d0),  32'd1);
        chk("t1_error", 32'(n_error - e0), 32'd0);
        chk("t1_ready", 32'(send_ready),   32'd1);

        // Table of single frames including a NACK
        for (int i = 0; i < 4; i++) begin
            d0 = n_done; e0 = n_error;
            send_byte(vecs[i].data);
            dev_frame(vecs[i].ack, st, bits);
            repeat (10) @(negedge clock);
            chk($sformatf("v%0d_start", i), 32'(st), 32'd0);
            chk($sformatf("v%0d_bits", i),  32'(bits), 32'(vecs[i].exp_bits));
            chk($sformatf("v%0d_done", i),  32'(n_done - d0),  32'(vecs[i].exp_done));
            chk($sformatf("v%0d_error", i), 32'(n_error - e0), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_oe", i), {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
            chk($sformatf("v%0d_ready", i), 32'(send_ready), 32'd1);
        end

        // Test 2: back-to-back 0x01 then 0x00 with valid held
        d0 = n_done; a0 = n_acc;
        @(negedge clock);
        send_valid = 1'b1;
        send_data  = 8'h01;
        @(negedge clock);
        send_data  = 8'h00;
        dev_frame(1'b1, st, bits);
        chk("t2_bits0", 32'(bits), 32'h201);
        chk("t2_acc_during_frame", 32'(n_acc - a0), 32'd1);
        k = 0;
        while (n_acc < a0 + 2 && k < 60) begin
            @(negedge clock);
            k++;
        end
        send_valid = 1'b0;
        chk("t2_second_accept", 32'(n_acc - a0), 32'd2);
        chk("t2_done_before_accept", 32'(n_done - d0), 32'd1);
        dev_frame(1'b1, st, bits);
        chk("t2_bits1", 32'(bits), 32'h300);
        repeat (10) @(negedge clock);
        chk("t2_done", 32'(n_done - d0), 32'd2);
        chk("t2_acc",  32'(n_acc - a0),  32'd2);

        // Test 4: device never clocks
        e0 = n_error; d0 = n_done;
        send_byte(8'h5A);
        wait_req(seen);
        chk("t4_req_seen", 32'(seen), 32'd1);
        err_at = 0; oe_at_err = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (error && err_at == 0) begin
                err_at = n;
                oe_at_err = ps2_clock_oe | ps2_data_oe;
            end
        end
        chk("t4_error_time", 32'(err_at), 32'd201);
        chk("t4_oe_at_error", 32'(oe_at_err), 32'd0);
        chk("t4_error_count", 32'(n_error - e0), 32'd1);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);
        chk("t4_released", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);

        // Test 5: reset during data bit 4
        send_byte(8'h55);
        wait_req(seen);
        chk("t5_req_seen", 32'(seen), 32'd1);
        repeat (4) dev_pulse();
        repeat (20) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clock);
        d0 = n_done; e0 = n_error;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_oe_after_reset", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        chk("t5_tx_active", 32'(tx_active), 32'd0);
        chk("t5_ready_in_reset", 32'(send_ready), 32'd0);
        dev_clk_low = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        chk("t5_no_done",  32'(n_done - d0),  32'd0);
        chk("t5_no_error", 32'(n_error - e0), 32'd0);
        chk("t5_ready", 32'(send_ready), 32'd1);
        d0 = n_done;
        send_byte(8'hFF);
        dev_frame(1'b1, st, bits);
        repeat (10) @(negedge clock);
        chk("t5_bits_ff", 32'(bits), 32'h3FF);
        chk("t5_done_ff", 32'(n_done - d0), 32'd1);

        // Test 6: valid held high with changing data during the frame
        d0 = n_done; a0 = n_acc;
        @(negedge clock);
        send_valid = 1'b1;
        send_data  = 8'h3C;
        @(negedge clock);
        fdone = 1'b0;
        fork
            begin
                dev_frame(1'b1, st, bits);
                fdone = 1'b1;
            end
            begin
                while (!fdone) begin
                    @(negedge clock);
                    send_data = 8'($urandom);
                end
            end
        join
        send_valid = 1'b0;
        repeat (20) @(negedge clock);
        chk("t6_bits", 32'(bits), 32'h33C);
        chk("t6_acc", 32'(n_acc - a0), 32'd1);
        chk("t6_done", 32'(n_done - d0), 32'd1);
        chk("t6_idle", 32'(tx_active), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
